// File: rtl/panel_key_sequencer_pkg.sv
// rtl/panel_key_sequencer_pkg.sv - shared encodings, FSM states and priority helpers
package panel_key_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_START     = 3'd1,
    CMD_LOAD_ADDR = 3'd2,
    CMD_DEP       = 3'd3,
    CMD_EXAM      = 3'd4,
    CMD_CONT      = 3'd5,
    CMD_STOP      = 3'd6
  } cmd_op_t;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SING_INST = 2'b01,
    MODE_SING_STEP = 2'b10
  } cmd_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_HOLD
  } state_t;

  localparam int NUM_KEYS      = 6;
  localparam int KEY_START     = 0;
  localparam int KEY_LOAD_ADDR = 1;
  localparam int KEY_DEP       = 2;
  localparam int KEY_EXAM      = 3;
  localparam int KEY_CONT      = 4;
  localparam int KEY_STOP      = 5;

  // Fixed priority: stop, start, load_addr, cont, exam, dep
  function automatic cmd_op_t pick_op(input logic [NUM_KEYS-1:0] mask);
    if (mask[KEY_STOP])           return CMD_STOP;
    else if (mask[KEY_START])     return CMD_START;
    else if (mask[KEY_LOAD_ADDR]) return CMD_LOAD_ADDR;
    else if (mask[KEY_CONT])      return CMD_CONT;
    else if (mask[KEY_EXAM])      return CMD_EXAM;
    else if (mask[KEY_DEP])       return CMD_DEP;
    else                          return CMD_NONE;
  endfunction

  // Pending-mask bit that corresponds to a command code
  function automatic logic [NUM_KEYS-1:0] op_key(input cmd_op_t op);
    logic [NUM_KEYS-1:0] k;
    k = '0;
    case (op)
      CMD_START:     k[KEY_START]     = 1'b1;
      CMD_LOAD_ADDR: k[KEY_LOAD_ADDR] = 1'b1;
      CMD_DEP:       k[KEY_DEP]       = 1'b1;
      CMD_EXAM:      k[KEY_EXAM]      = 1'b1;
      CMD_CONT:      k[KEY_CONT]      = 1'b1;
      CMD_STOP:      k[KEY_STOP]      = 1'b1;
      default:       k                = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/panel_key_sequencer_if.sv
// rtl/panel_key_sequencer_if.sv - console command handshake between sequencer and CPU
interface panel_key_sequencer_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic       cmd_done;

  modport master (output cmd_valid, output cmd_op, output cmd_mode,
                  input  cmd_ready, input  cmd_done);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_mode,
                  output cmd_ready, output cmd_done);
endinterface

// File: rtl/panel_key_edge.sv
// rtl/panel_key_edge.sv - rising-edge detector for the debounced panel key levels
module panel_key_edge
  import panel_key_sequencer_pkg::*;
#(
  parameter int WIDTH = NUM_KEYS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_prev;

  // Previous level, preset to ones so a key held through reset must be released first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= '1;
    else     r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/panel_key_sequencer.sv
// rtl/panel_key_sequencer.sv - serializes panel key presses into console commands
module panel_key_sequencer
  import panel_key_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         load_addr,
  input  logic                         dep,
  input  logic                         exam,
  input  logic                         cont,
  input  logic                         stop,
  input  logic                         sing_step,
  input  logic                         sing_inst,
  input  logic                         run,
  panel_key_sequencer_if.master        cmd,
  output logic                         busy,
  output logic                         err_timeout
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_next;
  logic [NUM_KEYS-1:0] w_level, w_rise, w_set, w_clr, r_pending;
  cmd_op_t             r_op, w_pick;
  cmd_mode_t           r_mode, w_mode;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                w_take, w_accept, w_done, w_timeout, w_hold_end;

  assign w_level = {stop, cont, exam, dep, load_addr, start};

  panel_key_edge #(.WIDTH(NUM_KEYS)) u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (w_level),
    .o_rise  (w_rise)
  );

  // While running only STOP is meaningful; while halted STOP is meaningless
  assign w_set      = run ? (w_rise & op_key(CMD_STOP)) : (w_rise & ~op_key(CMD_STOP));
  assign w_pick     = pick_op(r_pending);
  assign w_take     = (r_state == ST_IDLE) && (r_pending != '0);
  assign w_clr      = w_take ? op_key(w_pick) : '0;
  assign w_accept   = (r_state == ST_ISSUE) && cmd.cmd_ready;
  assign w_done     = (r_state == ST_WAIT_DONE) && cmd.cmd_done;
  assign w_timeout  = (r_state == ST_WAIT_DONE) && !cmd.cmd_done && (r_tmo_cnt == TMO_LAST);
  assign w_hold_end = (r_state == ST_HOLD) && (r_hold_cnt == HOLD_LAST);

  // Stepping modes only apply to commands that let the CPU execute
  always_comb begin
    w_mode = MODE_RUN;
    if ((w_pick == CMD_START) || (w_pick == CMD_CONT)) begin
      if (sing_step)      w_mode = MODE_SING_STEP;
      else if (sing_inst) w_mode = MODE_SING_INST;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_take)               w_next = ST_ISSUE;
      ST_ISSUE:     if (w_accept)             w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (w_done || w_timeout)  w_next = ST_HOLD;
      ST_HOLD:      if (w_hold_end)           w_next = ST_IDLE;
      default:                                w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the registered command
  always_comb begin
    cmd.cmd_valid = (r_state == ST_ISSUE);
    cmd.cmd_op    = r_op;
    cmd.cmd_mode  = r_mode;
    busy          = (r_state != ST_IDLE);
  end

  // Pending mask; a new edge wins over the clear from the IDLE decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr) | w_set;
  end

  // Command register loaded on the IDLE decision and returned to none after HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= CMD_NONE;
      r_mode <= MODE_RUN;
    end else if (w_take) begin
      r_op   <= w_pick;
      r_mode <= w_mode;
    end else if (w_hold_end) begin
      r_op   <= CMD_NONE;
      r_mode <= MODE_RUN;
    end
  end

  // Completion timeout; the error flag stays set until the next command is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt   <= '0;
      err_timeout <= 1'b0;
    end else if (w_accept) begin
      r_tmo_cnt   <= '0;
      err_timeout <= 1'b0;
    end else if (w_timeout) begin
      err_timeout <= 1'b1;
    end else if (r_state == ST_WAIT_DONE && !cmd.cmd_done) begin
      r_tmo_cnt   <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Guard-gap counter, restarted every time HOLD is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_hold_cnt <= '0;
    else if (r_state != ST_HOLD) r_hold_cnt <= '0;
    else if (!w_hold_end)        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
  end

endmodule

// File: doc/panel_key_sequencer.md
Name: panel_key_sequencer

Overview:
Converts the debounced front-panel key levels (START, LOAD ADD, DEP, EXAM, CONT, STOP) plus the SING STEP/SING INST mode switches into single, serialized console commands for the CPU core.
- Sits between the panel scan/debounce logic and the CPU console interface.
- Edge-detects and queues key presses, filters them against run state, and arbitrates simultaneous presses by fixed priority.
- Issues one command at a time over a valid/ready handshake, then waits for completion, with a timeout and an inter-command guard gap.

Parameters:
- HOLD_CYCLES, 16: idle guard cycles after each completed or timed-out command before the next issue (minimum 1).
- TIMEOUT_CYCLES, 1000000: maximum cycles in WAIT_DONE before abandoning the command.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  debounced START key level
- load_addr  input  1  debounced LOAD ADD key level
- dep  input  1  debounced DEP key level
- exam  input  1  debounced EXAM key level
- cont  input  1  debounced CONT key level
- stop  input  1  debounced STOP key level
- sing_step  input  1  SING STEP switch level
- sing_inst  input  1  SING INST switch level
- run  input  1  CPU run flip-flop
- cmd_valid  output  1  command offered to CPU
- cmd_op  output  3  command code: 0 none, 1 start, 2 load_addr, 3 dep, 4 exam, 5 cont, 6 stop
- cmd_mode  output  2  mode: 00 run, 01 single-instruction, 10 single-step
- cmd_ready  input  1  CPU accepts the offered command
- cmd_done  input  1  one-cycle pulse when the accepted command has completed
- busy  output  1  high whenever the FSM is not in IDLE
- err_timeout  output  1  sticky flag, set when a command times out

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE, pending mask = 0, counters = 0.
  - cmd_valid=0, cmd_op=0, cmd_mode=00, busy=0, err_timeout=0.
  - All six previous-level registers are set to 1, so a key held through reset never fires; it must be released and pressed again.
- Edge detect: rise[k] = level[k] & ~prev[k]; prev updates every cycle.
- Run filter, applied at edge time:
  - run=1: only a STOP rise sets its pending bit; other rises are discarded, not deferred.
  - run=0: a STOP rise is discarded; all other rises set their pending bits.
- Pending mask: 6 bits.
  - A set and a clear of the same bit in the same cycle: the set wins.
  - A repeated rise on an already-pending bit leaves it pending once; presses do not count.
- Priority, highest first: stop, start, load_addr, cont, exam, dep.
- FSM states: IDLE, ISSUE, WAIT_DONE, HOLD.
  - IDLE: if the mask is nonzero, select the highest-priority bit, clear it, and register cmd_op and cmd_mode. cmd_mode = 10 if sing_step, else 01 if sing_inst, else 00; it is forced to 00 for ops other than start/cont. Go to ISSUE. Latency from key rise to cmd_valid is 2 cycles when idle (one for the edge register, one for the IDLE decision).
  - ISSUE: cmd_valid=1, with cmd_op and cmd_mode held stable until cmd_ready is sampled high. On that cycle cmd_valid drops next cycle, the timeout counter clears, err_timeout clears, and the FSM goes to WAIT_DONE. There is no timeout in ISSUE; it waits indefinitely for cmd_ready.
  - WAIT_DONE: on cmd_done, go to HOLD. If TIMEOUT_CYCLES elapse first, set err_timeout and go to HOLD. A cmd_done arriving in any other state is ignored.
  - HOLD: count HOLD_CYCLES, then go to IDLE and set cmd_op to 0.
- Edge detection and pending updates continue in every state, so a STOP pressed during WAIT_DONE of a START (with run=1) is queued and issued after HOLD.
- run is sampled per cycle at edge time. If run falls while STOP is pending, the STOP stays pending and is still issued; the CPU treats it as a no-op.
- Counter widths: $clog2 of the respective parameter plus 1; no wrap-around is permitted.

Decomposition:
- Shared panel package holds the cmd_op encodings (CMD_NONE..CMD_STOP), the cmd_mode encodings, and the FSM state enum.
- One sub-module: panel_key_edge (6-bit rising-edge detector with asynchronous preset of the previous-level register), instantiated once.

Test Plan:
- START pulse with run=0, cmd_ready tied 1, cmd_done 5 cycles later -> cmd_valid high 1 cycle, cmd_op=1, cmd_mode=00, busy falls 16 cycles after done.
- dep, exam and load_addr rising in the same cycle with run=0 -> three commands issued in order op=2, 4, 3, each separated by HOLD.
- run=1, press exam then stop -> only op=6 issued; exam never issued, even after run drops.
- cont with sing_step=1 and sing_inst=1 -> op=5, mode=10. Then dep with sing_step=1 -> op=3, mode=00.
- With TIMEOUT_CYCLES=100, accept a start and never pulse cmd_done -> err_timeout=1 at cycle 100 after acceptance, then HOLD, then IDLE; the next accepted command clears err_timeout.
- Hold start high across reset release, then assert rst mid-ISSUE -> no command after the first release; cmd_valid drops asynchronously and the pending mask is empty afterwards.
